// File: rtl/bm1387_spi_slave.sv
// Chip-side SPI responder for the BM1387 model: oversampled mode-0 link, LSB first, READ and WRITE_CONTROL commands.
// Optional build macro BM1387_SPI_PARITY_EN appends an even-parity bit to every READ response.
module bm1387_spi_slave #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk_100m,
    input  logic        reset_n,
    input  logic        spi_clk,
    input  logic        spi_cs_n,
    input  logic        spi_mosi,
    output logic        spi_miso,
    input  logic [15:0] config_reg,
    input  logic [7:0]  status_reg,
    input  logic [7:0]  temperature,
    input  logic [15:0] power_consumption,
    output logic [7:0]  ctrl_wr_data,
    output logic        ctrl_wr_valid,
    output logic        cmd_err,
    output logic        busy
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CMD   = 3'd1,
        ST_ADDR  = 3'd2,
        ST_RDATA = 3'd3,
        ST_WDATA = 3'd4,
        ST_DRAIN = 3'd5
    } state_t;

    localparam logic [7:0] CMD_READ  = 8'h01;
    localparam logic [7:0] CMD_WRITE = 8'h02;

`ifdef BM1387_SPI_PARITY_EN
    localparam logic [4:0] LAST_FALL = 5'd16;

    function automatic logic even_parity(input logic [15:0] word);
        return ^word;
    endfunction
`else
    localparam logic [4:0] LAST_FALL = 5'd15;
`endif

    logic [SYNC_STAGES-1:0] sclk_sync_r;
    logic [SYNC_STAGES-1:0] cs_sync_r;
    logic [SYNC_STAGES-1:0] mosi_sync_r;
    logic                   sclk_prev_r;

    logic sclk_s, cs_n_s, mosi_s, rise_s, fall_s;

    state_t      state_r, state_nxt_s;
    logic [4:0]  bit_cnt_r, bit_cnt_nxt_s;
    logic [7:0]  shift_r, shift_nxt_s;
    logic [7:0]  cmd_r, cmd_nxt_s;
    logic [7:0]  addr_r, addr_nxt_s;
    logic [15:0] snap_r, snap_nxt_s;
    logic        miso_r, miso_nxt_s;
    logic [7:0]  ctrl_data_r, ctrl_data_nxt_s;
    logic        ctrl_valid_r, ctrl_valid_nxt_s;
    logic        cmd_err_r, cmd_err_nxt_s;
    logic        busy_r;

    logic [7:0]  byte_s;
    logic        byte_done_s;
    logic        cmd_legal_s;
    logic [15:0] map_word_s;
    logic        rd_bit_s;

    // Input synchronizers plus the previous-sample flop used for edge detection
    always_ff @(posedge clk_100m or negedge reset_n) begin
        if (!reset_n) begin
            sclk_sync_r <= '0;
            cs_sync_r   <= '1;
            mosi_sync_r <= '0;
            sclk_prev_r <= 1'b0;
        end else begin
            sclk_sync_r <= {sclk_sync_r[SYNC_STAGES-2:0], spi_clk};
            cs_sync_r   <= {cs_sync_r[SYNC_STAGES-2:0], spi_cs_n};
            mosi_sync_r <= {mosi_sync_r[SYNC_STAGES-2:0], spi_mosi};
            sclk_prev_r <= sclk_s;
        end
    end

    assign sclk_s = sclk_sync_r[SYNC_STAGES-1];
    assign cs_n_s = cs_sync_r[SYNC_STAGES-1];
    assign mosi_s = mosi_sync_r[SYNC_STAGES-1];
    // Edges coinciding with a deasserted CS are dropped so an abort never shifts a stray bit
    assign rise_s = sclk_s & ~sclk_prev_r & ~cs_n_s;
    assign fall_s = ~sclk_s & sclk_prev_r & ~cs_n_s;

    assign byte_s      = {mosi_s, shift_r[7:1]};
    assign byte_done_s = rise_s && (bit_cnt_r == 5'd7);
    assign cmd_legal_s = (byte_s == CMD_READ) || (byte_s == CMD_WRITE);

`ifdef BM1387_SPI_PARITY_EN
    assign rd_bit_s = bit_cnt_r[4] ? even_parity(snap_r) : snap_r[bit_cnt_r[3:0]];
`else
    assign rd_bit_s = snap_r[bit_cnt_r[3:0]];
`endif

    // Register map decode for the read snapshot, keyed by the incoming address byte
    always_comb begin
        map_word_s = 16'h0000;
        case (byte_s)
            8'h00:   map_word_s = config_reg;
            8'h01:   map_word_s = {8'h00, status_reg};
            8'h02:   map_word_s = {8'h00, temperature};
            8'h03:   map_word_s = power_consumption;
            default: map_word_s = 16'h0000;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk_100m or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_nxt_s = state_r;
        if (cs_n_s) begin
            state_nxt_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE:  state_nxt_s = ST_CMD;
                ST_CMD:   state_nxt_s = byte_done_s ? (cmd_legal_s ? ST_ADDR : ST_DRAIN) : ST_CMD;
                ST_ADDR:  state_nxt_s = byte_done_s ? ((cmd_r == CMD_READ) ? ST_RDATA : ST_WDATA) : ST_ADDR;
                ST_RDATA: state_nxt_s = (fall_s && (bit_cnt_r == LAST_FALL)) ? ST_DRAIN : ST_RDATA;
                ST_WDATA: state_nxt_s = byte_done_s ? ST_DRAIN : ST_WDATA;
                ST_DRAIN: state_nxt_s = ST_DRAIN;
                default:  state_nxt_s = ST_IDLE;
            endcase
        end
    end

    // FSM output and datapath next values
    always_comb begin
        bit_cnt_nxt_s    = bit_cnt_r;
        shift_nxt_s      = shift_r;
        cmd_nxt_s        = cmd_r;
        addr_nxt_s       = addr_r;
        snap_nxt_s       = snap_r;
        miso_nxt_s       = miso_r;
        ctrl_data_nxt_s  = ctrl_data_r;
        ctrl_valid_nxt_s = 1'b0;
        cmd_err_nxt_s    = 1'b0;
        if (cs_n_s) begin
            bit_cnt_nxt_s = 5'd0;
            shift_nxt_s   = 8'h00;
            miso_nxt_s    = 1'b0;
        end else begin
            case (state_r)
                ST_CMD, ST_ADDR, ST_WDATA: begin
                    if (byte_done_s) begin
                        bit_cnt_nxt_s = 5'd0;
                        shift_nxt_s   = 8'h00;
                    end else if (rise_s) begin
                        bit_cnt_nxt_s = bit_cnt_r + 5'd1;
                        shift_nxt_s   = byte_s;
                    end else begin
                        bit_cnt_nxt_s = bit_cnt_r;
                    end
                    if (byte_done_s && (state_r == ST_CMD)) begin
                        cmd_nxt_s     = byte_s;
                        cmd_err_nxt_s = !cmd_legal_s;
                    end else if (byte_done_s && (state_r == ST_ADDR)) begin
                        addr_nxt_s = byte_s;
                        snap_nxt_s = (cmd_r == CMD_READ) ? map_word_s : snap_r;
                    end else if (byte_done_s) begin
                        if (addr_r == 8'h00) begin
                            ctrl_data_nxt_s  = byte_s;
                            ctrl_valid_nxt_s = 1'b1;
                        end else begin
                            cmd_err_nxt_s = 1'b1;
                        end
                    end else begin
                        cmd_nxt_s = cmd_r;
                    end
                end
                ST_RDATA: begin
                    if (fall_s) begin
                        miso_nxt_s    = rd_bit_s;
                        bit_cnt_nxt_s = (bit_cnt_r == LAST_FALL) ? 5'd0 : (bit_cnt_r + 5'd1);
                    end else begin
                        miso_nxt_s = miso_r;
                    end
                end
                ST_DRAIN: begin
                    if (fall_s) begin
                        miso_nxt_s = 1'b0;
                    end else begin
                        miso_nxt_s = miso_r;
                    end
                end
                default: begin
                    bit_cnt_nxt_s = 5'd0;
                    shift_nxt_s   = 8'h00;
                    miso_nxt_s    = 1'b0;
                end
            endcase
        end
    end

    // Datapath and output registers
    always_ff @(posedge clk_100m or negedge reset_n) begin
        if (!reset_n) begin
            bit_cnt_r    <= 5'd0;
            shift_r      <= 8'h00;
            cmd_r        <= 8'h00;
            addr_r       <= 8'h00;
            snap_r       <= 16'h0000;
            miso_r       <= 1'b0;
            ctrl_data_r  <= 8'h00;
            ctrl_valid_r <= 1'b0;
            cmd_err_r    <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            bit_cnt_r    <= bit_cnt_nxt_s;
            shift_r      <= shift_nxt_s;
            cmd_r        <= cmd_nxt_s;
            addr_r       <= addr_nxt_s;
            snap_r       <= snap_nxt_s;
            miso_r       <= miso_nxt_s;
            ctrl_data_r  <= ctrl_data_nxt_s;
            ctrl_valid_r <= ctrl_valid_nxt_s;
            cmd_err_r    <= cmd_err_nxt_s;
            busy_r       <= ~cs_n_s;
        end
    end

    assign spi_miso      = miso_r;
    assign ctrl_wr_data  = ctrl_data_r;
    assign ctrl_wr_valid = ctrl_valid_r;
    assign cmd_err       = cmd_err_r;
    assign busy          = busy_r;

endmodule

// File: tb/tb_bm1387_spi_slave.sv
// Directed bench for bm1387_spi_slave: host-side SPI driver with scoreboards for read words and control writes.
module tb_bm1387_spi_slave;

    localparam int HALF = 6;

    logic        clk_100m = 1'b0;
    logic        reset_n  = 1'b0;
    logic        spi_clk  = 1'b0;
    logic        spi_cs_n = 1'b1;
    logic        spi_mosi = 1'b0;
    logic        spi_miso;
    logic [15:0] config_reg        = 16'h1234;
    logic [7:0]  status_reg        = 8'h5A;
    logic [7:0]  temperature       = 8'h33;
    logic [15:0] power_consumption = 16'hBEEF;
    logic [7:0]  ctrl_wr_data;
    logic        ctrl_wr_valid;
    logic        cmd_err;
    logic        busy;

    int errors = 0;
    int checks = 0;
    int valid_cnt = 0;
    int err_cnt = 0;
    logic [16:0] rd_exp_q[$];
    logic [7:0]  wr_exp_q[$];

    bm1387_spi_slave #(.SYNC_STAGES(2)) dut (
        .clk_100m(clk_100m), .reset_n(reset_n),
        .spi_clk(spi_clk), .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi), .spi_miso(spi_miso),
        .config_reg(config_reg), .status_reg(status_reg), .temperature(temperature),
        .power_consumption(power_consumption),
        .ctrl_wr_data(ctrl_wr_data), .ctrl_wr_valid(ctrl_wr_valid),
        .cmd_err(cmd_err), .busy(busy)
    );

    initial forever #5 clk_100m = ~clk_100m;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Pulse monitor: counts strobes and pops the write scoreboard on every control update
    always @(negedge clk_100m) begin
        if (reset_n && cmd_err) err_cnt++;
        if (reset_n && ctrl_wr_valid) begin
            valid_cnt++;
            if (wr_exp_q.size() > 0) check("wr_data", {24'h0, ctrl_wr_data}, {24'h0, wr_exp_q.pop_front()});
            else check("wr_unexpected", 32'd1, 32'd0);
        end
    end

    function automatic logic exp_tail(input logic [15:0] w);
`ifdef BM1387_SPI_PARITY_EN
        return ^w;
`else
        return 1'b0;
`endif
    endfunction

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk_100m);
        #1;
    endtask

    task automatic spi_bit(input logic b, output logic m);
        spi_mosi = b;
        wait_cyc(HALF);
        m = spi_miso;
        spi_clk = 1'b1;
        wait_cyc(HALF);
        spi_clk = 1'b0;
    endtask

    task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
        logic m;
        for (int i = 0; i < 8; i++) begin
            spi_bit(tx[i], m);
            rx[i] = m;
        end
    endtask

    task automatic read_bits(input int first, input int n, inout logic [16:0] rx);
        logic m;
        for (int i = first; i < first + n; i++) begin
            spi_bit(1'b0, m);
            rx[i] = m;
        end
    endtask

    task automatic cs_begin();
        spi_cs_n = 1'b0;
        wait_cyc(HALF);
    endtask

    task automatic cs_end();
        wait_cyc(HALF);
        spi_cs_n = 1'b1;
        wait_cyc(10);
    endtask

    task automatic read_frame(input logic [7:0] addr, input logic [15:0] exp_word, input string tag);
        logic [7:0]  dummy;
        logic [16:0] rx;
        rx = 17'h0;
        rd_exp_q.push_back({exp_tail(exp_word), exp_word});
        cs_begin();
        spi_byte(8'h01, dummy);
        spi_byte(addr, dummy);
        read_bits(0, 17, rx);
        cs_end();
        check(tag, {15'h0, rx}, {15'h0, rd_exp_q.pop_front()});
    endtask

    initial begin
        logic [7:0]  rx8;
        logic [16:0] rx;
        logic        m;
        logic        acc;

        wait_cyc(5);
        check("rst_miso",  {31'h0, spi_miso}, 32'd0);
        check("rst_data",  {24'h0, ctrl_wr_data}, 32'd0);
        check("rst_valid", {31'h0, ctrl_wr_valid}, 32'd0);
        check("rst_err",   {31'h0, cmd_err}, 32'd0);
        check("rst_busy",  {31'h0, busy}, 32'd0);
        reset_n = 1'b1;
        wait_cyc(5);

        // READ addr 0x00 with busy observed mid-frame
        rx = 17'h0;
        rd_exp_q.push_back({exp_tail(16'h1234), 16'h1234});
        cs_begin();
        spi_byte(8'h01, rx8);
        check("busy_mid", {31'h0, busy}, 32'd1);
        spi_byte(8'h00, rx8);
        read_bits(0, 17, rx);
        cs_end();
        check("rd_cfg", {15'h0, rx}, {15'h0, rd_exp_q.pop_front()});
        check("busy_idle", {31'h0, busy}, 32'd0);
        check("no_err_rd", err_cnt, 32'd0);

        // WRITE_CONTROL addr 0x00 data 0xA5
        wr_exp_q.push_back(8'hA5);
        cs_begin();
        spi_byte(8'h02, rx8);
        spi_byte(8'h00, rx8);
        spi_byte(8'hA5, rx8);
        cs_end();
        check("wr_pulses", valid_cnt, 32'd1);
        check("wr_hold", {24'h0, ctrl_wr_data}, 32'h0000_00A5);
        check("wr_q_empty", wr_exp_q.size(), 32'd0);

        // WRITE_CONTROL to illegal address 0x05
        cs_begin();
        spi_byte(8'h02, rx8);
        spi_byte(8'h05, rx8);
        spi_byte(8'h3C, rx8);
        cs_end();
        check("badaddr_err", err_cnt, 32'd1);
        check("badaddr_data", {24'h0, ctrl_wr_data}, 32'h0000_00A5);
        check("badaddr_valid", valid_cnt, 32'd1);

        // Illegal command: one error after the command byte, MISO quiet afterwards
        cs_begin();
        spi_byte(8'h7F, rx8);
        check("badcmd_err", err_cnt, 32'd2);
        acc = 1'b0;
        for (int i = 0; i < 24; i++) begin
            spi_bit(i[0], m);
            acc = acc | m;
        end
        cs_end();
        check("badcmd_miso", {31'h0, acc}, 32'd0);
        check("badcmd_err_once", err_cnt, 32'd2);

        read_frame(8'h03, 16'hBEEF, "rd_power");

        // Abort after four write-data bits
        cs_begin();
        spi_byte(8'h02, rx8);
        spi_byte(8'h00, rx8);
        acc = 1'b0;
        for (int i = 0; i < 4; i++) begin
            spi_bit(1'b1, m);
            acc = acc | m;
        end
        cs_end();
        check("abort_valid", valid_cnt, 32'd1);
        check("abort_miso", {31'h0, spi_miso | acc}, 32'd0);
        check("abort_data", {24'h0, ctrl_wr_data}, 32'h0000_00A5);

        read_frame(8'h01, 16'h005A, "rd_status");

        // Snapshot must survive a source change during the data phase
        config_reg = 16'h1234;
        rx = 17'h0;
        rd_exp_q.push_back({exp_tail(16'h1234), 16'h1234});
        cs_begin();
        spi_byte(8'h01, rx8);
        spi_byte(8'h00, rx8);
        read_bits(0, 6, rx);
        config_reg = 16'hFFFF;
        read_bits(6, 11, rx);
        cs_end();
        check("rd_snapshot", {15'h0, rx}, {15'h0, rd_exp_q.pop_front()});

        config_reg = 16'h0007;
        read_frame(8'h00, 16'h0007, "rd_tail_7");
        config_reg = 16'h0003;
        read_frame(8'h00, 16'h0003, "rd_tail_3");
        read_frame(8'h02, 16'h0033, "rd_temp");
        read_frame(8'h09, 16'h0000, "rd_unmapped");
        check("final_err", err_cnt, 32'd2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
